// File: rtl/id_operand_stage.sv
// Decode-side operand stage: drives the register file read ports, bypasses from EX/WB,
// inserts one bubble on load-use, and registers resolved operands into the ID/EX register.
module id_operand_stage #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_rs,
  input  logic [AW-1:0]    in_rt,
  input  logic             in_rs_used,
  input  logic             in_rt_used,
  input  logic [AW-1:0]    in_wa,
  input  logic             in_we,
  input  logic             in_is_load,
  output logic [AW-1:0]    ra1,
  output logic [AW-1:0]    ra2,
  input  logic [DW-1:0]    rd1,
  input  logic [DW-1:0]    rd2,
  input  logic             ex_valid,
  input  logic             ex_we,
  input  logic             ex_is_load,
  input  logic [AW-1:0]    ex_wa,
  input  logic [DW-1:0]    ex_wd,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_wa,
  input  logic [DW-1:0]    wb_wd,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_op_a,
  output logic [DW-1:0]    out_op_b,
  output logic [AW-1:0]    out_wa,
  output logic             out_we,
  output logic             out_is_load,
  output logic [CNT_W-1:0] stall_count
);

  logic          ex_fwd_ok;
  logic          hazard;
  logic          adv;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;

  // A load in EX has no data yet, so it never forwards; the load-use stall covers it.
  function automatic logic [DW-1:0] resolve(
    input logic [AW-1:0] src,
    input logic [DW-1:0] rf_data,
    input logic          ex_ok,
    input logic [AW-1:0] e_wa,
    input logic [DW-1:0] e_wd,
    input logic          w_we,
    input logic [AW-1:0] w_wa,
    input logic [DW-1:0] w_wd
  );
    if (src == '0)                  return '0;
    else if (ex_ok && e_wa == src)  return e_wd;
    else if (w_we && w_wa == src)   return w_wd;
    else                            return rf_data;
  endfunction

  assign ra1       = in_rs;
  assign ra2       = in_rt;
  assign ex_fwd_ok = ex_valid && ex_we && !ex_is_load;

  assign op_a = resolve(in_rs, rd1, ex_fwd_ok, ex_wa, ex_wd, wb_we, wb_wa, wb_wd);
  assign op_b = resolve(in_rt, rd2, ex_fwd_ok, ex_wa, ex_wd, wb_we, wb_wa, wb_wd);

  assign hazard = in_valid && ex_valid && ex_is_load && ex_we && (ex_wa != '0) &&
                  ((in_rs_used && in_rs == ex_wa) || (in_rt_used && in_rt == ex_wa));

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !hazard && !flush;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_op_a    <= '0;
      out_op_b    <= '0;
      out_wa      <= '0;
      out_we      <= 1'b0;
      out_is_load <= 1'b0;
      stall_count <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      if (hazard) begin
        out_valid <= 1'b0;
        if (stall_count != '1) stall_count <= stall_count + CNT_W'(1);
      end else if (in_valid) begin
        out_valid   <= 1'b1;
        out_op_a    <= op_a;
        out_op_b    <= op_b;
        out_wa      <= in_wa;
        out_we      <= in_we;
        out_is_load <= in_is_load;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage: directed scenarios followed by randomized traffic
// against a behavioural model of forwarding, load-use stalls and the ID/EX handshake.
module tb_id_operand_stage;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 4;  // small so counter saturation is reached

  typedef struct packed {
    logic          rst;
    logic          in_valid;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          rs_used;
    logic          rt_used;
    logic [AW-1:0] wa;
    logic          we;
    logic          is_load;
    logic          ex_valid;
    logic          ex_we;
    logic          ex_is_load;
    logic [AW-1:0] ex_wa;
    logic [DW-1:0] ex_wd;
    logic          wb_we;
    logic [AW-1:0] wb_wa;
    logic [DW-1:0] wb_wd;
    logic          flush;
    logic          out_ready;
  } stim_t;

  typedef struct packed {
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [AW-1:0] wa;
    logic          we;
    logic          is_load;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0, in_ready;
  logic [AW-1:0]    in_rs = '0, in_rt = '0, in_wa = '0;
  logic             in_rs_used = 1'b0, in_rt_used = 1'b0, in_we = 1'b0, in_is_load = 1'b0;
  logic [AW-1:0]    ra1, ra2;
  logic [DW-1:0]    rd1, rd2;
  logic             ex_valid = 1'b0, ex_we = 1'b0, ex_is_load = 1'b0;
  logic [AW-1:0]    ex_wa = '0;
  logic [DW-1:0]    ex_wd = '0;
  logic             wb_we = 1'b0;
  logic [AW-1:0]    wb_wa = '0;
  logic [DW-1:0]    wb_wd = '0;
  logic             flush = 1'b0;
  logic             out_valid, out_ready = 1'b0;
  logic [DW-1:0]    out_op_a, out_op_b;
  logic [AW-1:0]    out_wa;
  logic             out_we, out_is_load;
  logic [CNT_W-1:0] stall_count;

  logic [DW-1:0]    rf [32];
  stim_t            st;
  exp_t             sb_q[$];
  int               n_checks = 0;
  int               n_err = 0;
  logic             m_known = 1'b0;
  logic             m_valid = 1'b0;
  int               m_stall = 0;

  id_operand_stage #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rs_used(in_rs_used), .in_rt_used(in_rt_used),
    .in_wa(in_wa), .in_we(in_we), .in_is_load(in_is_load),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_wa(ex_wa), .ex_wd(ex_wd),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_wa(out_wa), .out_we(out_we),
    .out_is_load(out_is_load), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference operand value straight from the forwarding priority rules.
  function automatic logic [DW-1:0] model_operand(input logic [AW-1:0] src);
    if (src == 0) return '0;
    if (st.ex_valid && st.ex_we && !st.ex_is_load && st.ex_wa == src) return st.ex_wd;
    if (st.wb_we && st.wb_wa == src) return st.wb_wd;
    return rf[src];
  endfunction

  // One clock: apply st after the edge, check combinational/state outputs at the negedge,
  // then advance the model to what the next edge should produce.
  task automatic step();
    logic hz, adv, rdy;
    exp_t e;
    @(posedge clk);
    #1;
    if (wb_we && wb_wa != 0) rf[wb_wa] = wb_wd;
    rst = st.rst; in_valid = st.in_valid; in_rs = st.rs; in_rt = st.rt;
    in_rs_used = st.rs_used; in_rt_used = st.rt_used; in_wa = st.wa; in_we = st.we;
    in_is_load = st.is_load; ex_valid = st.ex_valid; ex_we = st.ex_we;
    ex_is_load = st.ex_is_load; ex_wa = st.ex_wa; ex_wd = st.ex_wd;
    wb_we = st.wb_we; wb_wa = st.wb_wa; wb_wd = st.wb_wd;
    flush = st.flush; out_ready = st.out_ready;
    @(negedge clk);
    hz  = st.in_valid && st.ex_valid && st.ex_is_load && st.ex_we && st.ex_wa != 0 &&
          ((st.rs_used && st.rs == st.ex_wa) || (st.rt_used && st.rt == st.ex_wa));
    adv = !m_valid || st.out_ready;
    rdy = adv && !hz && !st.flush;
    if (m_known) begin
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("stall_count", 64'(stall_count), 64'(m_stall));
      check("in_ready", 64'(in_ready), 64'(rdy));
      check("ra1", 64'(ra1), 64'(st.rs));
      check("ra2", 64'(ra2), 64'(st.rt));
    end
    if (st.rst) begin
      m_known = 1'b1; m_valid = 1'b0; m_stall = 0;
      sb_q.delete();
    end else if (st.flush) begin
      if (m_valid && !st.out_ready && sb_q.size() > 0) void'(sb_q.pop_back());
      m_valid = 1'b0;
    end else if (adv && hz) begin
      m_valid = 1'b0;
      if (m_stall != (1 << CNT_W) - 1) m_stall++;
    end else if (adv && st.in_valid) begin
      e.op_a = model_operand(st.rs);
      e.op_b = model_operand(st.rt);
      e.wa = st.wa; e.we = st.we; e.is_load = st.is_load;
      sb_q.push_back(e);
      m_valid = 1'b1;
    end else if (adv) begin
      m_valid = 1'b0;
    end
  endtask

  // Monitor: every handshake on the ID/EX side retires the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 64'(1), 64'(0));
        end else begin
          e = sb_q.pop_front();
          check("op_a", 64'(out_op_a), 64'(e.op_a));
          check("op_b", 64'(out_op_b), 64'(e.op_b));
          check("wa", 64'(out_wa), 64'(e.wa));
          check("we", 64'(out_we), 64'(e.we));
          check("is_load", 64'(out_is_load), 64'(e.is_load));
        end
      end
    end
  end

  function automatic stim_t instr(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                                  input logic [AW-1:0] wa);
    stim_t s = '0;
    s.in_valid = 1'b1; s.rs = rs; s.rt = rt; s.rs_used = 1'b1; s.rt_used = 1'b1;
    s.wa = wa; s.we = 1'b1; s.out_ready = 1'b1;
    return s;
  endfunction

  task automatic idle(input logic ready);
    st = '0; st.out_ready = ready;
    step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? '0 : $urandom;
    rf[3] = 32'h11;
    rf[4] = 32'h22;

    st = '0; st.rst = 1'b1;
    step(); step();
    check("rst_op_a", 64'(out_op_a), 64'(0));
    check("rst_op_b", 64'(out_op_b), 64'(0));

    // Plain register file read
    st = instr(5'd3, 5'd4, 5'd9); step();
    idle(1'b1);
    check("rf_op_a", 64'(out_op_a), 64'h11);
    check("rf_op_b", 64'(out_op_b), 64'h22);

    // EX beats WB on the same register
    st = instr(5'd5, 5'd4, 5'd10);
    st.ex_valid = 1'b1; st.ex_we = 1'b1; st.ex_wa = 5'd5; st.ex_wd = 32'hAAAA;
    st.wb_we = 1'b1; st.wb_wa = 5'd5; st.wb_wd = 32'hBBBB;
    step();
    idle(1'b1);
    check("ex_over_wb", 64'(out_op_a), 64'hAAAA);

    // Register 0 ignores both bypass paths
    st = instr(5'd3, 5'd0, 5'd11);
    st.ex_valid = 1'b1; st.ex_we = 1'b1; st.ex_wa = 5'd0; st.ex_wd = 32'hFFFF;
    st.wb_we = 1'b1; st.wb_wa = 5'd0; st.wb_wd = 32'hFFFF;
    step();
    idle(1'b1);
    check("r0_op_b", 64'(out_op_b), 64'(0));

    // Load-use: one bubble, then WB bypass delivers the load data
    st = instr(5'd7, 5'd4, 5'd12);
    st.ex_valid = 1'b1; st.ex_we = 1'b1; st.ex_is_load = 1'b1; st.ex_wa = 5'd7;
    step();
    check("lu_in_ready", 64'(in_ready), 64'(0));
    st = instr(5'd7, 5'd4, 5'd12);
    st.wb_we = 1'b1; st.wb_wa = 5'd7; st.wb_wd = 32'h1234;
    step();
    check("lu_bubble", 64'(out_valid), 64'(0));
    check("lu_accept", 64'(in_ready), 64'(1));
    check("lu_count", 64'(stall_count), 64'(1));
    idle(1'b1);
    check("lu_op_a", 64'(out_op_a), 64'h1234);

    // Downstream back-pressure for 3 cycles
    st = instr(5'd1, 5'd2, 5'd13); step();
    st = instr(5'd2, 5'd3, 5'd14); st.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_in_ready", 64'(in_ready), 64'(0));
    end
    st.out_ready = 1'b1; step();
    idle(1'b1);

    // Flush with an occupied stage and a presented instruction
    st = instr(5'd3, 5'd4, 5'd15); st.out_ready = 1'b0; step();
    st = instr(5'd6, 5'd6, 5'd16); st.out_ready = 1'b0; st.flush = 1'b1; step();
    check("flush_in_ready", 64'(in_ready), 64'(0));
    idle(1'b1);
    check("flush_valid", 64'(out_valid), 64'(0));

    // Reset mid-stream
    st = instr(5'd3, 5'd4, 5'd17); st.out_ready = 1'b0; step();
    st = '0; st.rst = 1'b1; step();
    idle(1'b1);
    check("mrst_valid", 64'(out_valid), 64'(0));
    check("mrst_op_a", 64'(out_op_a), 64'(0));
    check("mrst_wa", 64'(out_wa), 64'(0));
    check("mrst_count", 64'(stall_count), 64'(0));

    // Randomized traffic with heavy register aliasing
    for (int n = 0; n < 3000; n++) begin
      st = '0;
      st.in_valid   = ($urandom_range(0, 9) < 8);
      st.rs         = AW'($urandom_range(0, 7));
      st.rt         = AW'($urandom_range(0, 7));
      st.rs_used    = $urandom_range(0, 3) != 0;
      st.rt_used    = $urandom_range(0, 3) != 0;
      st.wa         = AW'($urandom);
      st.we         = $urandom_range(0, 1);
      st.is_load    = $urandom_range(0, 1);
      st.ex_valid   = $urandom_range(0, 9) < 7;
      st.ex_we      = $urandom_range(0, 3) != 0;
      st.ex_is_load = $urandom_range(0, 9) < 3;
      st.ex_wa      = AW'($urandom_range(0, 7));
      st.ex_wd      = $urandom;
      st.wb_we      = $urandom_range(0, 1);
      st.wb_wa      = AW'($urandom_range(0, 7));
      st.wb_wd      = $urandom;
      st.flush      = $urandom_range(0, 19) == 0;
      st.out_ready  = $urandom_range(0, 9) < 7;
      step();
    end

    for (int i = 0; i < 3; i++) idle(1'b1);
    check("scoreboard_drained", 64'(sb_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
